// File: rtl/instr_fetch_if.sv
// instr_fetch_if: host and datapath signals of the program sequencer.
// The host side drives program, init and control; the sequencer drives the rest.
interface instr_fetch_if #(
   parameter int ADDR_W = 6
);
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [15:0]       prog_data;
   logic              init_we;
   logic [3:0]        init_addr;
   logic [15:0]       init_data;
   logic              start;
   logic              stall;
   logic [15:0]       Instruction;
   logic [15:0]       DataInit;
   logic              InitSel;
   logic [ADDR_W-1:0] pc;
   logic              running;
   logic              halted;
   logic [15:0]       issue_count;

   modport master (
      output prog_we, prog_addr, prog_data,
      output init_we, init_addr, init_data,
      output start, stall,
      input  Instruction, DataInit, InitSel,
      input  pc, running, halted, issue_count
   );

   modport slave (
      input  prog_we, prog_addr, prog_data,
      input  init_we, init_addr, init_data,
      input  start, stall,
      output Instruction, DataInit, InitSel,
      output pc, running, halted, issue_count
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: program sequencer feeding the register-file/ALU datapath.
// Loads a program, performs register-init writes, then issues one word per cycle.
module instr_fetch #(
   parameter int          ADDR_W    = 6,
   parameter logic [15:0] NOP_INSTR = 16'h7000,
   parameter logic [3:0]  WR_OP     = 4'h0,
   parameter logic [3:0]  HALT_OP   = 4'hF,
   parameter logic [3:0]  JMP_OP    = 4'hE
) (
   input logic         clk,
   input logic         reset,
   instr_fetch_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   state_t            state, state_nxt;
   logic [15:0]       mem [0:DEPTH-1];
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [15:0]       instr_q, instr_nxt;
   logic [15:0]       data_q, data_nxt;
   logic              sel_q, sel_nxt;
   logic [15:0]       cnt_q, cnt_nxt;
   logic [15:0]       word;
   logic [3:0]        op;

   // Combinational fetch of the word at the current pc.
   assign word = mem[pc_q];
   assign op   = word[15:12];

   // Host program writes; locked out while a program is executing.
   always_ff @(posedge clk) begin
      if (bus.prog_we && state != RUN)
         mem[bus.prog_addr] <= bus.prog_data;
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         data_q  <= '0;
         sel_q   <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state   <= state_nxt;
         pc_q    <= pc_nxt;
         instr_q <= instr_nxt;
         data_q  <= data_nxt;
         sel_q   <= sel_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // Next state: start/init handling when parked, fetch/issue when running.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      instr_nxt = NOP_INSTR;
      data_nxt  = data_q;
      sel_nxt   = 1'b1;
      cnt_nxt   = cnt_q;
      unique case (state)
         IDLE, HALT: begin
            if (bus.start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
               cnt_nxt   = '0;
            end else if (bus.init_we) begin
               instr_nxt = {WR_OP, bus.init_addr, 8'h00};
               data_nxt  = bus.init_data;
               sel_nxt   = 1'b0;
            end
         end
         RUN: begin
            if (bus.stall) begin
               instr_nxt = NOP_INSTR;
            end else if (op == HALT_OP) begin
               state_nxt = HALT;
            end else if (op == JMP_OP) begin
               pc_nxt = word[ADDR_W-1:0];
            end else begin
               instr_nxt = word;
               if (cnt_q != 16'hFFFF)
                  cnt_nxt = cnt_q + 16'd1;
               if (pc_q == LAST)
                  state_nxt = HALT;
               else
                  pc_nxt = pc_q + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.Instruction = instr_q;
   assign bus.DataInit    = data_q;
   assign bus.InitSel     = sel_q;
   assign bus.pc          = pc_q;
   assign bus.issue_count = cnt_q;
   assign bus.running     = (state == RUN);
   assign bus.halted      = (state == HALT);

endmodule
